display_scan_ctrl: RTL

//  Time-multiplexes one shared 7-segment decoder across NUM_DIGITS digits of the clock display.

---
 rtl/display_scan_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan controller (optional blinking under BLINK_EN)
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int CLK_DIV      = 50000,
    parameter int GUARD        = 16
`ifdef BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
`ifdef BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
    output logic [3:0]              dec_code_o,
    input  logic [6:0]              seg_in_i,
    output logic [6:0]              seg_out_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_start_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [0:0]              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [3:0]              dec_code_q, dec_code_d;
    logic                    blank_q, blank_d;
    logic [6:0]              seg_q;
    logic                    frame_start_q;

    logic                    frame_edge;
    logic [4*NUM_DIGITS-1:0] src;
    logic [3:0]              nib;
    logic                    blank_now;

`ifdef BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start_q) begin
            if (frame_cnt_q == FC_MAX) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        state_d = (cnt_d >= CNT_GUARD) ? ST_DRIVE : ST_GUARD;

        frame_edge = (cnt_q == '0) && (idx_q == '0);
        snap_d     = frame_edge ? digits_i : snap_q;
        // Slot 0 reads the word being captured this cycle, not the stale snapshot
        src        = frame_edge ? digits_i : snap_q;

        nib       = 4'hF;
        blank_now = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = src[4*i +: 4];
`ifdef BLINK_EN
                blank_now = blank_mask_i[i] | (blink_mask_i[i] & blink_phase_q);
`else
                blank_now = blank_mask_i[i];
`endif
            end
        end

        dec_code_d = dec_code_q;
        blank_d    = blank_q;
        if (cnt_q == '0) begin
            dec_code_d = blank_now ? 4'hF : nib;
            blank_d    = blank_now;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            state_q       <= ST_GUARD;
            snap_q        <= '1;
            dec_code_q    <= 4'hF;
            blank_q       <= 1'b1;
            seg_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            snap_q        <= snap_d;
            dec_code_q    <= dec_code_d;
            blank_q       <= blank_d;
            seg_q         <= seg_in_i;
            frame_start_q <= frame_edge;
        end
    end

    always_comb begin
        an_o = '1;
        if (state_q == ST_DRIVE && !blank_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_o[i] = 1'b0;
                end
            end
        end
    end

    assign dec_code_o    = dec_code_q;
    assign seg_out_o     = seg_q;
    assign frame_start_o = frame_start_q;

endmodule
